// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle controller and the datapath.
// The datapath returns the decoded op/func fields. The controller drives mux selects and write strobes.
interface mc_ctrl_if;
   logic [5:0] op;
   logic [5:0] func;
   logic       irwrite;
   logic       pcwrite;
   logic       regwrite;
   logic       memwrite;
   logic [1:0] wactr;
   logic [1:0] wdctr;
   logic       extctr;
   logic       bctr;
   logic [2:0] aluctr;
   logic [1:0] brctr;

   modport master (
      input  op, func,
      output irwrite, pcwrite, regwrite, memwrite,
             wactr, wdctr, extctr, bctr, aluctr, brctr
   );

   modport slave (
      output op, func,
      input  irwrite, pcwrite, regwrite, memwrite,
             wactr, wdctr, extctr, bctr, aluctr, brctr
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// op-decoded mux selects and state-qualified write strobes.
module mc_ctrl (
   input  logic             clk,
   input  logic             rst,
   mc_ctrl_if.master        bus,
   output logic [2:0]       state,
   output logic [31:0]      retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t cur, nxt;

   logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_nop;
   logic irwrite, pcwrite, regwrite, memwrite;

   assign is_addu = (bus.op == 6'b000000) && (bus.func == 6'b100001);
   assign is_subu = (bus.op == 6'b000000) && (bus.func == 6'b100011);
   assign is_jr   = (bus.op == 6'b000000) && (bus.func == 6'b001000);
   assign is_ori  = (bus.op == 6'b001101);
   assign is_lui  = (bus.op == 6'b001111);
   assign is_lw   = (bus.op == 6'b100011);
   assign is_sw   = (bus.op == 6'b101011);
   assign is_beq  = (bus.op == 6'b000100);
   assign is_j    = (bus.op == 6'b000010);
   assign is_jal  = (bus.op == 6'b000011);
   assign is_nop  = !(is_addu | is_subu | is_jr | is_ori | is_lui | is_lw |
                      is_sw | is_beq | is_j | is_jal);

   // Mux selects depend only on the decode and are held for the whole instruction.
   always_comb begin
      bus.wactr  = 2'b00;
      bus.wdctr  = 2'b00;
      bus.extctr = 1'b0;
      bus.bctr   = 1'b0;
      bus.aluctr = 3'b000;
      bus.brctr  = 2'b00;
      if (is_addu) begin
         bus.wactr = 2'b01;
      end
      if (is_subu) begin
         bus.wactr  = 2'b01;
         bus.aluctr = 3'b001;
      end
      if (is_ori) begin
         bus.bctr   = 1'b1;
         bus.aluctr = 3'b010;
      end
      if (is_lui) begin
         bus.bctr   = 1'b1;
         bus.aluctr = 3'b011;
      end
      if (is_lw) begin
         bus.wdctr  = 2'b01;
         bus.extctr = 1'b1;
         bus.bctr   = 1'b1;
      end
      if (is_sw) begin
         bus.extctr = 1'b1;
         bus.bctr   = 1'b1;
      end
      if (is_beq) begin
         bus.aluctr = 3'b001;
         bus.brctr  = 2'b01;
      end
      if (is_j) begin
         bus.brctr = 2'b10;
      end
      if (is_jal) begin
         bus.wactr = 2'b10;
         bus.wdctr = 2'b10;
         bus.brctr = 2'b10;
      end
      if (is_jr) begin
         bus.brctr = 2'b11;
      end
   end

   // Next-state and strobe decode; reset masks every strobe so an aborted
   // instruction commits nothing. irwrite depends on the state only.
   always_comb begin
      nxt      = S_FETCH;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      case (cur)
         S_FETCH: begin
            irwrite = 1'b1;
            nxt     = S_DECODE;
         end
         S_DECODE: begin
            if (is_j | is_jr | is_nop) begin
               pcwrite = 1'b1;
            end else if (is_jal) begin
               pcwrite  = 1'b1;
               regwrite = 1'b1;
            end else begin
               nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_addu | is_subu | is_ori | is_lui) begin
               nxt = S_WB;
            end else if (is_lw | is_sw) begin
               nxt = S_MEM;
            end else if (is_beq) begin
               pcwrite = 1'b1;
            end
         end
         S_MEM: begin
            if (is_sw) begin
               memwrite = 1'b1;
               pcwrite  = 1'b1;
            end else if (is_lw) begin
               nxt = S_WB;
            end
         end
         S_WB: begin
            regwrite = 1'b1;
            pcwrite  = 1'b1;
         end
         default: nxt = S_FETCH;
      endcase
      if (rst) begin
         irwrite  = 1'b0;
         pcwrite  = 1'b0;
         regwrite = 1'b0;
         memwrite = 1'b0;
      end
   end

   // State register and retired-instruction counter, bumped on each PC commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur     <= S_FETCH;
         retired <= '0;
      end else begin
         cur <= nxt;
         if (pcwrite) begin
            retired <= retired + 32'd1;
         end
      end
   end

   assign state        = cur;
   assign bus.irwrite  = irwrite;
   assign bus.pcwrite  = pcwrite;
   assign bus.regwrite = regwrite;
   assign bus.memwrite = memwrite;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction behavioural model built
// from the CPI table and select table, with random instruction streams and
// random mid-instruction resets.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  state;
   logic [31:0] retired;

   always #5 clk = ~clk;

   mc_ctrl_if bus();

   mc_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .state   (state),
      .retired (retired)
   );

   typedef struct {
      int unsigned n;
      logic        wreg;
      logic        wmem;
      logic [1:0]  wa;
      logic [1:0]  wd;
      logic        ext;
      logic        b;
      logic [2:0]  alu;
      logic [1:0]  br;
   } spec_t;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic [31:0] model_cnt = '0;

   logic        chk_on  = 1'b0;
   logic        chk_st  = 1'b0;
   logic        chk_sel = 1'b0;
   logic [2:0]  e_state;
   logic        e_ir, e_pc, e_rw, e_mw;
   logic [31:0] e_ret;
   spec_t       e_spec;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Instruction behaviour as listed in the select and CPI tables.
   function automatic spec_t lookup(input logic [5:0] o, input logic [5:0] f);
      spec_t s;
      s.n = 2; s.wreg = 1'b0; s.wmem = 1'b0; s.wa = 2'b00; s.wd = 2'b00;
      s.ext = 1'b0; s.b = 1'b0; s.alu = 3'b000; s.br = 2'b00;
      case (o)
         6'b000000: begin
            if (f == 6'b100001) begin s.n = 4; s.wreg = 1'b1; s.wa = 2'b01; end
            if (f == 6'b100011) begin s.n = 4; s.wreg = 1'b1; s.wa = 2'b01; s.alu = 3'b001; end
            if (f == 6'b001000) begin s.br = 2'b11; end
         end
         6'b001101: begin s.n = 4; s.wreg = 1'b1; s.b = 1'b1; s.alu = 3'b010; end
         6'b001111: begin s.n = 4; s.wreg = 1'b1; s.b = 1'b1; s.alu = 3'b011; end
         6'b100011: begin s.n = 5; s.wreg = 1'b1; s.wd = 2'b01; s.ext = 1'b1; s.b = 1'b1; end
         6'b101011: begin s.n = 4; s.wmem = 1'b1; s.ext = 1'b1; s.b = 1'b1; end
         6'b000100: begin s.n = 3; s.alu = 3'b001; s.br = 2'b01; end
         6'b000010: begin s.br = 2'b10; end
         6'b000011: begin s.wreg = 1'b1; s.wa = 2'b10; s.wd = 2'b10; s.br = 2'b10; end
         default: ;
      endcase
      return s;
   endfunction

   // State visited in cycle k of an instruction: FETCH, DECODE, EXEC, then MEM
   // for memory ops, and WB as the last cycle of anything that writes the GRF late.
   function automatic logic [2:0] path_at(input spec_t s, input int unsigned k);
      if (k < 3) return 3'(k);
      if (k == 3 && (s.wmem || s.n == 5)) return 3'd3;
      return 3'd4;
   endfunction

   // Single compare process: checks every cycle marked meaningful by the driver.
   always @(negedge clk) begin
      if (chk_on) begin
         check("irwrite",  32'(bus.irwrite),  32'(e_ir));
         check("pcwrite",  32'(bus.pcwrite),  32'(e_pc));
         check("regwrite", 32'(bus.regwrite), 32'(e_rw));
         check("memwrite", 32'(bus.memwrite), 32'(e_mw));
         if (chk_st) begin
            check("state",   32'(state), 32'(e_state));
            check("retired", retired,    e_ret);
         end
         if (chk_sel) begin
            check("wactr",  32'(bus.wactr),  32'(e_spec.wa));
            check("wdctr",  32'(bus.wdctr),  32'(e_spec.wd));
            check("extctr", 32'(bus.extctr), 32'(e_spec.ext));
            check("bctr",   32'(bus.bctr),   32'(e_spec.b));
            check("aluctr", 32'(bus.aluctr), 32'(e_spec.alu));
            check("brctr",  32'(bus.brctr),  32'(e_spec.br));
         end
      end
   end

   // Entered at the start of a FETCH cycle (#1 after the edge). Runs the whole
   // instruction, or only stop_at cycles when stop_at is nonzero and shorter.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                            input int unsigned stop_at, output logic [2:0] next_state);
      spec_t s;
      int unsigned last;
      s = lookup(o, f);
      bus.op   = o;
      bus.func = f;
      e_spec   = s;
      last = (stop_at != 0 && stop_at < s.n) ? stop_at : s.n;
      for (int unsigned k = 0; k < last; k++) begin
         e_state = path_at(s, k);
         e_ir    = (k == 0);
         e_pc    = (k == s.n - 1);
         e_rw    = e_pc && s.wreg;
         e_mw    = e_pc && s.wmem;
         e_ret   = model_cnt;
         chk_on  = 1'b1;
         chk_st  = 1'b1;
         chk_sel = (k > 0);
         @(posedge clk);
         #1;
         if (k == s.n - 1) model_cnt = model_cnt + 32'd1;
      end
      next_state = path_at(s, last);
   endtask

   task automatic do_reset(input int unsigned n, input logic [2:0] first_state, input logic first_known);
      rst = 1'b1;
      for (int unsigned i = 0; i < n; i++) begin
         e_ir    = 1'b0;
         e_pc    = 1'b0;
         e_rw    = 1'b0;
         e_mw    = 1'b0;
         e_state = (i == 0) ? first_state : 3'd0;
         e_ret   = (i == 0) ? model_cnt : 32'd0;
         chk_on  = 1'b1;
         chk_st  = (i > 0) || first_known;
         chk_sel = 1'b0;
         @(posedge clk);
         #1;
         model_cnt = '0;
      end
      rst = 1'b0;
   endtask

   logic [11:0] legal [10] = '{
      {6'b000000, 6'b100001}, {6'b000000, 6'b100011}, {6'b000000, 6'b001000},
      {6'b001101, 6'b000000}, {6'b001111, 6'b000000}, {6'b100011, 6'b000000},
      {6'b101011, 6'b000000}, {6'b000100, 6'b000000}, {6'b000010, 6'b000000},
      {6'b000011, 6'b000000}
   };

   initial begin
      logic [2:0]  ns;
      logic [5:0]  o, f;
      logic [11:0] pick;
      spec_t       s;

      rst      = 1'b1;
      bus.op   = 6'b000000;
      bus.func = 6'b000000;

      do_reset(2, 3'd0, 1'b0);

      // lw aborted by a 3-cycle reset while in MEM
      run_instr(6'b100011, 6'b000000, 3, ns);
      do_reset(3, ns, 1'b1);
      check("post_reset_state_lit", 32'(state), 32'd0);
      check("post_reset_retired_lit", retired, 32'd0);

      // addu
      run_instr(6'b000000, 6'b100001, 0, ns);
      check("addu_retired_lit", retired, 32'd1);

      // lw then sw back-to-back
      run_instr(6'b100011, 6'b000000, 0, ns);
      run_instr(6'b101011, 6'b000000, 0, ns);
      check("lw_sw_retired_lit", retired, 32'd3);

      // beq, jal, jr, undefined op
      run_instr(6'b000100, 6'b000000, 0, ns);
      run_instr(6'b000011, 6'b000000, 0, ns);
      run_instr(6'b000000, 6'b001000, 0, ns);
      run_instr(6'b111111, 6'b000000, 0, ns);
      check("after_nop_retired_lit", retired, 32'd7);

      // counter wrap: preload all-ones during FETCH, a NOP retires it to zero
      force dut.retired = 32'hFFFF_FFFF;
      #1;
      release dut.retired;
      model_cnt = 32'hFFFF_FFFF;
      run_instr(6'b111111, 6'b010101, 0, ns);
      check("wrap_retired_lit", retired, 32'd0);

      // randomized stream with occasional mid-instruction resets
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            o = 6'($urandom);
            f = 6'($urandom);
         end else begin
            pick = legal[$urandom_range(0, 9)];
            o = pick[11:6];
            f = (o == 6'b000000) ? pick[5:0] : 6'($urandom);
         end
         if ($urandom_range(0, 19) == 0) begin
            s = lookup(o, f);
            run_instr(o, f, $urandom_range(1, s.n - 1), ns);
            do_reset($urandom_range(1, 3), ns, 1'b1);
         end else begin
            run_instr(o, f, 0, ns);
         end
      end

      chk_on = 1'b0;
      @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
